hazard_sb: RTL
==============

# hazard_sb

Parametrised load-use scoreboard replacing the fixed two-class stall detector between decode and execute. It tracks every in-flight long-latency write (GP loads, SR loads, future multi-cycle ops) per register class and per register, using a per-register countdown. It raises a stall while the decode-stage instruction reads or overwrites a register whose result is not yet available. It also supports EX-stage flush cancellation, pipeline freeze and a saturating stall counter.

## Interface
Parameters:
- NUM_CLASS, 2: number of register classes (0 = GP, 1 = SR).
- REG_AW, 4: register address width per class.
- NUM_SRC, 2: operand ports checked per class (source and target both read).
- LOAD_LAT, 2: cycles from issue until the result is forwardable; must be ≥ 1.
- CNT_W, 16: stall performance counter width.

Ports:
- iw_clk, in, 1: clock.
- iw_rst, in, 1: reset, asynchronous, active-high.
- iw_src_addr, in, NUM_CLASS*NUM_SRC*REG_AW: decode operand addresses; slot k = class*NUM_SRC + port.
- iw_src_vld, in, NUM_CLASS*NUM_SRC: operand slot is actually read or written.
- iw_issue, in, 1: decode instruction enters EX this cycle.
- iw_dst_cls, in, clog2(NUM_CLASS) (min 1): destination class of the issuing instruction.
- iw_dst_addr, in, REG_AW: destination register.
- iw_dst_we, in, 1: the issuing instruction writes a register.
- iw_dst_long, in, 1: the write is long-latency.
- iw_flush_ex, in, 1: the instruction in EX is killed this cycle.
- iw_freeze, in, 1: whole pipeline held (memory wait).
- ow_stall, out, 1: decode must not issue.
- ow_stall_cnt, out, CNT_W: saturating count of stalled cycles.
- ow_pending, out, NUM_CLASS*2**REG_AW: bitmap, counter ≠ 0.

## Operation
- Each register (class c, address a) has a counter cnt[c][a] of width clog2(LOAD_LAT+1).
- Issue with iw_dst_we & iw_dst_long, no flush and no freeze: cnt[dst] <= LOAD_LAT.
- Issue with iw_dst_we & !iw_dst_long: cnt[dst] <= 0.
- Otherwise a nonzero counter decrements by 1 per cycle while iw_freeze=0. While frozen, all counters hold.
- Last-issue record (valid, class, addr): loaded on every long issue, cleared on a non-long issue or after one non-frozen cycle.
- iw_flush_ex with a valid record: that counter is cleared to 0, overriding the decrement. An iw_issue in the same cycle is ignored, because decode is also flushed.
- ow_stall = OR over valid slots k of (cnt[class(k)][iw_src_addr slot k] ≠ 0). It is combinational from the registered counters and current decode inputs.
- Reading the destination of an instruction issuing this cycle does not stall that cycle. The following decode instruction sees cnt = LOAD_LAT.
- WAW: a destination listed in a valid slot stalls if pending. Issue onto a pending destination (protocol violation) overwrites the counter.
- Asserting iw_issue during iw_freeze is a protocol violation. It is ignored.
- ow_stall_cnt increments each cycle ow_stall=1 and iw_freeze=0. It saturates at all-ones.

## Timing
- Reset: all counters 0, record invalid, ow_stall_cnt 0, ow_pending 0, ow_stall 0 (decode vld low) or combinational with zero state.
- Load issued in cycle t: a dependent instruction stalls in cycles t+1 … t+LOAD_LAT and may issue in cycle t+LOAD_LAT+1. Each frozen cycle adds 1.
- ow_pending reflects the counters registered at the clock edge, with no extra latency.
- Reset mid-operation clears all pending state immediately. No stall survives reset.

## Structure
- Slot indexing macros and the class encodings GP=0 and SR=1 go in sizes.vh. Opcode-to-long decode stays in opcodes.vh and is performed by the decoder, not here.
- One sub-module: hazard_sb_cnt, a single-register countdown with load/clear/hold/decrement. It is instantiated NUM_CLASS*2**REG_AW times via generate.
- The stall OR-tree and the perf counter live in the top module.

## Test plan
- GP load to r3 issued at t=10, next instruction reads r3 (LOAD_LAT=2) -> ow_stall=1 at t=11,12 and 0 at t=13; ow_stall_cnt=2.
- SR load to s5, decode reads GP r5 -> no stall; decode reads s5 -> stall. This checks class separation.
- Load to r7 issued at t=20, iw_freeze=1 at t=21–23 -> stall held through t=25 and released at t=26; ow_stall_cnt=2.
- Load to r2 at t=30, iw_flush_ex at t=31 -> ow_pending bit r2 clears at t=32 and no stall at t=32. An iw_issue at t=31 sets nothing.
- Load to r4, then an ALU write to r4 is attempted while pending with the dest slot valid -> stall until the counter reaches 0, then issue clears cnt. Assert reset mid-stall -> ow_stall=0 and ow_pending=0 immediately.
- Sweep with LOAD_LAT=4, CNT_W=3, continuous dependent stalls -> ow_stall_cnt saturates at 7 and stays there.

Source files
------------

// File: rtl/hazard_sb_pkg.sv
// Shared definitions for the load-use scoreboard: register class encodings,
// operand-slot indexing and width helpers.
package hazard_sb_pkg;

  // Register class encodings.
  typedef enum logic [0:0] {
    ClsGp = 1'b0,
    ClsSr = 1'b1
  } reg_cls_e;

  // Flat operand slot index: slot k = class * num_src + port.
  function automatic int unsigned slot_idx(input int unsigned cls, input int unsigned port,
                                           input int unsigned num_src);
    return cls * num_src + port;
  endfunction

  // Width of a per-register countdown able to hold lat.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  // Width of the destination class field; never narrower than one bit.
  function automatic int unsigned cls_width(input int unsigned num_class);
    return (num_class > 1) ? $clog2(num_class) : 1;
  endfunction

endpackage

// File: rtl/hazard_sb_cnt.sv
// Single-register result countdown: clear beats load, load beats hold, and an
// idle nonzero count decrements toward "result forwardable".
module hazard_sb_cnt #(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_hold,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: flush/non-long overwrite, long-issue load, freeze hold, else count down.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_load) begin
      w_cnt_nxt = CNT_W'(LOAD_VAL);
    end else if (!i_hold && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously so no pending result survives reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_sb.sv
// Load-use scoreboard between decode and execute. One countdown per register
// and class tracks in-flight long-latency writes; decode stalls while any
// valid operand slot names a register whose result is not yet forwardable.
module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int unsigned NUM_CLASS = 2,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                                iw_clk,
  input  logic                                iw_rst,
  input  logic [NUM_CLASS*NUM_SRC*REG_AW-1:0] iw_src_addr,
  input  logic [NUM_CLASS*NUM_SRC-1:0]        iw_src_vld,
  input  logic                                iw_issue,
  input  logic [cls_width(NUM_CLASS)-1:0]     iw_dst_cls,
  input  logic [REG_AW-1:0]                   iw_dst_addr,
  input  logic                                iw_dst_we,
  input  logic                                iw_dst_long,
  input  logic                                iw_flush_ex,
  input  logic                                iw_freeze,
  output logic                                ow_stall,
  output logic [CNT_W-1:0]                    ow_stall_cnt,
  output logic [NUM_CLASS*(2**REG_AW)-1:0]    ow_pending
);

  localparam int unsigned CLS_W    = cls_width(NUM_CLASS);
  localparam int unsigned NUM_REG  = 2 ** REG_AW;
  localparam int unsigned NUM_SLOT = NUM_CLASS * NUM_SRC;
  localparam int unsigned CNT_BITS = cnt_width(LOAD_LAT);

  logic [NUM_CLASS-1:0][NUM_REG-1:0] w_pend;
  logic [NUM_SLOT-1:0]               w_slot_hit;
  logic                              w_issue_ok;
  logic                              w_flush_hit;

  logic              r_rec_vld;
  logic [CLS_W-1:0]  r_rec_cls;
  logic [REG_AW-1:0] r_rec_addr;
  logic [CNT_W-1:0]  r_stall_cnt;

  // An issue is dropped while frozen, and when EX is flushed decode is flushed too.
  assign w_issue_ok  = iw_issue & ~iw_freeze & ~iw_flush_ex;
  assign w_flush_hit = iw_flush_ex & r_rec_vld;

  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_cls
    for (genvar a = 0; a < NUM_REG; a++) begin : g_reg
      logic w_dst_hit;
      logic w_rec_hit;

      assign w_dst_hit = w_issue_ok & iw_dst_we & (iw_dst_cls == CLS_W'(c)) &
                         (iw_dst_addr == REG_AW'(a));
      assign w_rec_hit = w_flush_hit & (r_rec_cls == CLS_W'(c)) & (r_rec_addr == REG_AW'(a));

      hazard_sb_cnt #(
        .CNT_W   (CNT_BITS),
        .LOAD_VAL(LOAD_LAT)
      ) u_cnt (
        .i_clk (iw_clk),
        .i_rst (iw_rst),
        .i_clr (w_rec_hit | (w_dst_hit & ~iw_dst_long)),
        .i_load(w_dst_hit & iw_dst_long),
        .i_hold(iw_freeze),
        .o_busy(w_pend[c][a])
      );
    end
  end

  // Each operand slot looks up the pending bit of its own class.
  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_slot_cls
    for (genvar p = 0; p < NUM_SRC; p++) begin : g_slot_port
      localparam int unsigned K = slot_idx(c, p, NUM_SRC);
      assign w_slot_hit[K] = iw_src_vld[K] & w_pend[c][iw_src_addr[K*REG_AW +: REG_AW]];
    end
  end

  assign ow_stall   = |w_slot_hit;
  assign ow_pending = w_pend;

  // Last-issue record: names the long write a same-register EX flush must cancel.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_rec_vld  <= 1'b0;
      r_rec_cls  <= '0;
      r_rec_addr <= '0;
    end else if (iw_flush_ex) begin
      r_rec_vld <= 1'b0;
    end else if (w_issue_ok) begin
      r_rec_vld  <= iw_dst_we & iw_dst_long;
      r_rec_cls  <= iw_dst_cls;
      r_rec_addr <= iw_dst_addr;
    end else if (!iw_freeze) begin
      r_rec_vld <= 1'b0;
    end
  end

  // Saturating count of cycles decode was actually held by a hazard.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_stall_cnt <= '0;
    end else if (ow_stall && !iw_freeze && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign ow_stall_cnt = r_stall_cnt;

endmodule
